// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path: states, opcode
// classes, control-line bundle and encodings for alu_op / pc_src.
package cpu_pkg;

   typedef enum logic [2:0] {
      S_START  = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_e;

   typedef enum logic [3:0] {
      OP_RTYPE   = 4'd0,
      OP_ADDI    = 4'd1,
      OP_LW      = 4'd2,
      OP_SW      = 4'd3,
      OP_BEQ     = 4'd4,
      OP_J       = 4'd5,
      OP_NOP     = 4'd6,
      OP_HALT    = 4'd7,
      OP_ILLEGAL = 4'd8
   } op_e;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] PC_PLUS1  = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       halted;
   } ctrl_t;

   // HALT is the all-ones code of the configured opcode width; legal
   // non-HALT opcodes fit in the low three bits with the rest zero.
   function automatic op_e op_decode(input logic [31:0] opc, input int unsigned w);
      logic [31:0] halt_code;
      halt_code = (32'd1 << w) - 32'd1;
      if (opc == halt_code) return OP_HALT;
      if (opc > 32'd6) return OP_ILLEGAL;
      return op_e'(opc[3:0]);
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational map from FSM state and latched opcode class to the
// DataPath control lines.
module mc_ctrl_decode
   import cpu_pkg::*;
(
   input  state_e state_i,
   input  op_e    op_i,
   input  logic   zero_i,
   input  logic   mem_ready_i,
   output ctrl_t  ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.pc_src   = PC_PLUS1;
            ctrl_o.ir_write = mem_ready_i;
            ctrl_o.pc_write = mem_ready_i;
         end
         S_EXEC: begin
            case (op_i)
               OP_RTYPE: ctrl_o.alu_op = ALU_FUNCT;
               OP_ADDI, OP_LW, OP_SW: begin
                  ctrl_o.alu_op  = ALU_ADD;
                  ctrl_o.alu_src = 1'b1;
               end
               OP_BEQ: begin
                  ctrl_o.alu_op   = ALU_SUB;
                  ctrl_o.pc_src   = PC_BRANCH;
                  ctrl_o.pc_write = zero_i;
               end
               OP_J: begin
                  ctrl_o.pc_src   = PC_JUMP;
                  ctrl_o.pc_write = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.alu_op    = ALU_ADD;
            ctrl_o.mem_read  = (op_i == OP_LW);
            ctrl_o.mem_write = (op_i == OP_SW);
         end
         S_WB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.reg_dst    = (op_i == OP_RTYPE);
            ctrl_o.mem_to_reg = (op_i == OP_LW);
         end
         S_HALT: ctrl_o.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: state register, opcode latch, retire counter
// and sticky illegal-opcode flag around the control-line decoder.
//
// state  | meaning
// START  | post-reset idle cycle, all controls low
// FETCH  | read instruction, wait for mem_ready
// DECODE | classify opcode, latch it, retire NOP/illegal
// EXEC   | ALU operation, branch/jump resolution
// MEM    | data load/store, wait for mem_ready
// WB     | register file write
// HALT   | stopped until reset
module mc_control_unit #(
   parameter int OPCODE_W = 4,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode_i,
   input  logic                zero_i,
   input  logic                mem_ready_i,
   output logic                pc_write_o,
   output logic                ir_write_o,
   output logic                reg_dst_o,
   output logic                alu_src_o,
   output logic                mem_to_reg_o,
   output logic                reg_write_o,
   output logic                mem_read_o,
   output logic                mem_write_o,
   output logic [1:0]          alu_op_o,
   output logic [1:0]          pc_src_o,
   output logic                halted_o,
   output logic                illegal_op_o,
   output logic [CNT_W-1:0]    instr_count_o
);
   import cpu_pkg::*;

   state_e           state_q, state_d;
   op_e              op_q;
   op_e              op_dec;
   logic             illegal_q;
   logic [CNT_W-1:0] count_q;
   logic             retire;
   logic             illegal_set;
   ctrl_t            ctrl;

   assign op_dec = op_decode(32'(opcode_i), OPCODE_W);

   always_comb begin
      state_d     = state_q;
      retire      = 1'b0;
      illegal_set = 1'b0;
      case (state_q)
         S_START:  state_d = S_FETCH;
         S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
         S_DECODE: begin
            case (op_dec)
               OP_HALT: state_d = S_HALT;
               OP_NOP: begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               OP_ILLEGAL: begin
                  retire      = 1'b1;
                  illegal_set = 1'b1;
                  state_d     = S_FETCH;
               end
               default: state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (op_q)
               OP_RTYPE, OP_ADDI: state_d = S_WB;
               OP_LW, OP_SW:      state_d = S_MEM;
               default: begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEM: begin
            if (mem_ready_i) begin
               if (op_q == OP_LW) begin
                  state_d = S_WB;
               end else begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         S_WB: begin
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_START;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_START;
         op_q      <= OP_NOP;
         illegal_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) op_q <= op_dec;
         if (illegal_set) illegal_q <= 1'b1;
         if (retire) count_q <= count_q + CNT_W'(1);
      end
   end

   mc_ctrl_decode u_decode (
      .state_i     (state_q),
      .op_i        (op_q),
      .zero_i      (zero_i),
      .mem_ready_i (mem_ready_i),
      .ctrl_o      (ctrl)
   );

   assign pc_write_o    = ctrl.pc_write;
   assign ir_write_o    = ctrl.ir_write;
   assign reg_dst_o     = ctrl.reg_dst;
   assign alu_src_o     = ctrl.alu_src;
   assign mem_to_reg_o  = ctrl.mem_to_reg;
   assign reg_write_o   = ctrl.reg_write;
   assign mem_read_o    = ctrl.mem_read;
   assign mem_write_o   = ctrl.mem_write;
   assign alu_op_o      = ctrl.alu_op;
   assign pc_src_o      = ctrl.pc_src;
   assign halted_o      = ctrl.halted;
   assign illegal_op_o  = illegal_q;
   assign instr_count_o = count_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: a per-cycle vector table for the
// basic instruction mix, then hand-written stall, halt, reset and wrap cases.
module tb_mc_control_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [3:0]  opcode;
   logic        zero, mem_ready;
   logic        pc_write, ir_write, reg_dst, alu_src, mem_to_reg, reg_write;
   logic        mem_read, mem_write, halted, illegal_op;
   logic [1:0]  alu_op, pc_src;
   logic [15:0] instr_count;

   logic        rst_w_n;
   logic        w_pc_write, w_ir_write, w_reg_dst, w_alu_src, w_mem_to_reg, w_reg_write;
   logic        w_mem_read, w_mem_write, w_halted, w_illegal_op;
   logic [1:0]  w_alu_op, w_pc_src;
   logic [2:0]  w_count;

   mc_control_unit dut (
      .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(mem_ready),
      .pc_write_o(pc_write), .ir_write_o(ir_write), .reg_dst_o(reg_dst), .alu_src_o(alu_src),
      .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write), .mem_read_o(mem_read),
      .mem_write_o(mem_write), .alu_op_o(alu_op), .pc_src_o(pc_src), .halted_o(halted),
      .illegal_op_o(illegal_op), .instr_count_o(instr_count)
   );

   // Narrow counter instance so the wrap is reachable in a short run.
   mc_control_unit #(.OPCODE_W(4), .CNT_W(3)) u_wrap (
      .clk(clk), .rst_n(rst_w_n), .opcode_i(4'd6), .zero_i(1'b0), .mem_ready_i(1'b1),
      .pc_write_o(w_pc_write), .ir_write_o(w_ir_write), .reg_dst_o(w_reg_dst),
      .alu_src_o(w_alu_src), .mem_to_reg_o(w_mem_to_reg), .reg_write_o(w_reg_write),
      .mem_read_o(w_mem_read), .mem_write_o(w_mem_write), .alu_op_o(w_alu_op),
      .pc_src_o(w_pc_src), .halted_o(w_halted), .illegal_op_o(w_illegal_op),
      .instr_count_o(w_count)
   );

   logic [13:0] act;
   assign act = {pc_write, ir_write, reg_dst, alu_src, mem_to_reg, reg_write,
                 mem_read, mem_write, alu_op, pc_src, halted, illegal_op};

   localparam logic [13:0] PW   = 14'd1 << 13;
   localparam logic [13:0] IW   = 14'd1 << 12;
   localparam logic [13:0] RD   = 14'd1 << 11;
   localparam logic [13:0] AS   = 14'd1 << 10;
   localparam logic [13:0] M2R  = 14'd1 << 9;
   localparam logic [13:0] RW   = 14'd1 << 8;
   localparam logic [13:0] MRD  = 14'd1 << 7;
   localparam logic [13:0] MWR  = 14'd1 << 6;
   localparam logic [13:0] ASUB = 14'd1 << 4;
   localparam logic [13:0] AFN  = 14'd2 << 4;
   localparam logic [13:0] PBR  = 14'd1 << 2;
   localparam logic [13:0] PJ   = 14'd2 << 2;
   localparam logic [13:0] HLT  = 14'd1 << 1;
   localparam logic [13:0] ILL  = 14'd1;
   localparam logic [13:0] FRDY = PW | IW | MRD;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic        z;
      logic        rdy;
      logic [13:0] exp;
      int          cnt;
   } vec_t;

   vec_t vecs[$];
   int checks = 0;
   int errors = 0;

   task automatic add(input string n, input logic [3:0] op, input logic z, input logic rdy,
                      input logic [13:0] e, input int c);
      vec_t v;
      v.name = n; v.op = op; v.z = z; v.rdy = rdy; v.exp = e; v.cnt = c;
      vecs.push_back(v);
   endtask

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", n, a, e);
      end
   endtask

   initial begin
      // name, opcode, zero, mem_ready, expected controls, expected count
      add("start",    4'd0, 0, 1, 14'd0,            0);
      add("r_fetch",  4'd0, 0, 1, FRDY,             0);
      add("r_dec",    4'd0, 0, 0, 14'd0,            0);
      add("r_exec",   4'd0, 0, 0, AFN,              0);
      add("r_wb",     4'd0, 0, 0, RW | RD,          0);
      add("a_stall",  4'd1, 0, 0, MRD,              1);
      add("a_fetch",  4'd1, 0, 1, FRDY,             1);
      add("a_dec",    4'd1, 0, 1, 14'd0,            1);
      add("a_exec",   4'd1, 0, 0, AS,               1);
      add("a_wb",     4'd1, 0, 1, RW,               1);
      add("bz_fetch", 4'd4, 1, 1, FRDY,             2);
      add("bz_dec",   4'd4, 1, 1, 14'd0,            2);
      add("bz_exec",  4'd4, 1, 1, PW | ASUB | PBR,  2);
      add("bn_fetch", 4'd4, 0, 1, FRDY,             3);
      add("bn_dec",   4'd4, 0, 1, 14'd0,            3);
      add("bn_exec",  4'd4, 0, 1, ASUB | PBR,       3);
      add("j_fetch",  4'd5, 0, 1, FRDY,             4);
      add("j_dec",    4'd5, 0, 1, 14'd0,            4);
      add("j_exec",   4'd5, 0, 1, PW | PJ,          4);
      add("n_fetch",  4'd6, 0, 1, FRDY,             5);
      add("n_dec",    4'd6, 0, 1, 14'd0,            5);
      add("s_fetch",  4'd3, 0, 1, FRDY,             6);
      add("s_dec",    4'd3, 0, 1, 14'd0,            6);
      add("s_exec",   4'd3, 0, 1, AS,               6);
      add("s_mem",    4'd3, 0, 1, AS | MWR,         6);
      add("i_fetch",  4'd9, 0, 1, FRDY,             7);
      add("i_dec",    4'd9, 0, 1, 14'd0,            7);
      add("l_fetch",  4'd2, 0, 1, FRDY | ILL,       8);
      add("l_dec",    4'd2, 0, 1, ILL,              8);
      add("l_exec",   4'd2, 0, 1, AS | ILL,         8);
      add("l_mem",    4'd2, 0, 1, AS | MRD | ILL,   8);
      add("l_wb",     4'd2, 0, 1, RW | M2R | ILL,   8);
      add("e_stall",  4'd6, 0, 0, MRD | ILL,        9);

      rst_n = 1'b0; rst_w_n = 1'b0;
      opcode = 4'd0; zero = 1'b0; mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_ctl", 32'(act), 32'd0);
      chk("reset_cnt", 32'(instr_count), 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         opcode = vecs[i].op; zero = vecs[i].z; mem_ready = vecs[i].rdy;
         #1;
         chk({vecs[i].name, "_ctl"}, 32'(act), 32'(vecs[i].exp));
         chk({vecs[i].name, "_cnt"}, 32'(instr_count), 32'(vecs[i].cnt));
         @(negedge clk);
      end

      // LW with two stall cycles in FETCH and in MEM: nine cycles in all.
      begin
         logic [8:0] rdy_sched;
         rdy_sched = 9'b0_1000_1100;  // bit i = mem_ready in cycle i
         opcode = 4'd2;
         for (int i = 0; i < 9; i++) begin
            mem_ready = rdy_sched[i];
            #1;
            chk($sformatf("lw_irw_c%0d", i), 32'(ir_write), (i == 2) ? 32'd1 : 32'd0);
            if (i == 5) chk("lw_mem_stall", 32'(act), 32'(AS | MRD | ILL));
            if (i == 8) begin
               chk("lw_wb", 32'(act), 32'(RW | M2R | ILL));
               chk("lw_wb_cnt", 32'(instr_count), 32'd9);
            end
            @(negedge clk);
         end
         #1;
         chk("lw_retired_cnt", 32'(instr_count), 32'd10);
         chk("lw_back_fetch", 32'(mem_read), 32'd1);
      end

      // HALT: fetch, decode, then parked with only halted set.
      opcode = 4'hF; mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         mem_ready = i[0];
         #1;
         chk($sformatf("halt_c%0d", i), 32'(act), 32'(HLT | ILL));
         @(negedge clk);
      end
      #1;
      chk("halt_cnt", 32'(instr_count), 32'd10);

      rst_n = 1'b0; opcode = 4'd6; mem_ready = 1'b1;
      #1;
      chk("rst_pulse_ctl", 32'(act), 32'd0);
      chk("rst_pulse_cnt", 32'(instr_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_start", 32'(act), 32'd0);
      @(negedge clk);
      #1;
      chk("post_rst_fetch", 32'(act), 32'(FRDY));

      // NOP, then SW stalled in MEM with reset asserted mid-cycle.
      @(negedge clk);
      @(negedge clk);
      opcode = 4'd3;
      #1;
      chk("sw_pre_cnt", 32'(instr_count), 32'd1);
      @(negedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      #1;
      chk("sw_mem_write", 32'(act), 32'(AS | MWR));
      #2;
      rst_n = 1'b0;
      #1;
      chk("sw_abort_mwr", 32'(mem_write), 32'd0);
      chk("sw_abort_ctl", 32'(act), 32'd0);
      chk("sw_abort_cnt", 32'(instr_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Counter wrap on the narrow instance: 1 START edge + 2 per NOP.
      rst_w_n = 1'b1;
      repeat (15) @(negedge clk);
      #1;
      chk("wrap_cnt7", 32'(w_count), 32'd7);
      repeat (2) @(negedge clk);
      #1;
      chk("wrap_cnt0", 32'(w_count), 32'd0);
      repeat (2) @(negedge clk);
      #1;
      chk("wrap_cnt1", 32'(w_count), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Parametrised multi-cycle control unit for the 16-bit CPU, the successor to the single-cycle `cu`. It sequences each instruction through fetch/decode/execute/memory/writeback states and drives the DataPath control lines. It waits on a memory-ready handshake and keeps a sticky illegal-opcode flag and a retired-instruction counter. It sits between the CPU top and DataPath, taking `opcode` and `zero` from DataPath.

## Interface
- `OPCODE_W`, 4: opcode field width; must be ≥3. Upper bits beyond bit 2 must be 0 for a legal opcode, except HALT.
- `CNT_W`, 16: width of the retired-instruction counter.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `opcode`  in  OPCODE_W  opcode field of the instruction register, valid from DECODE onward.
- `zero`  in  1  ALU zero flag, sampled in EXEC.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `pc_write`, `ir_write`, `reg_dst`, `alu_src`, `mem_to_reg`, `reg_write`, `mem_read`, `mem_write`  out  1 each  DataPath controls.
- `alu_op`  out  2  00 add, 01 sub, 10 funct-decoded.
- `pc_src`  out  2  00 PC+1, 01 branch target, 10 jump target.
- `halted`  out  1  high in HALT.
- `illegal_op`  out  1  sticky illegal-opcode flag.
- `instr_count`  out  CNT_W  retired-instruction count.

## Operation
- Opcodes: 0 RTYPE, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 J, 6 NOP, all-ones HALT. Everything else is illegal.
- States: START, FETCH, DECODE, EXEC, MEM, WB, HALT. The opcode is latched on the DECODE cycle and held until the next FETCH.
- START: all control outputs 0. Goes to FETCH after one cycle.
- FETCH: `mem_read`=1 and `pc_src`=00.
  - If `mem_ready`=0: hold in FETCH.
  - If `mem_ready`=1: `ir_write`=1 and `pc_write`=1, then go to DECODE.
- DECODE: all controls 0.
  - HALT goes to HALT.
  - NOP retires and goes to FETCH.
  - Illegal: set `illegal_op`, retire, go to FETCH.
  - Otherwise go to EXEC.
- EXEC, per opcode:
  - RTYPE: `alu_op`=10, `alu_src`=0, then WB.
  - ADDI, LW, SW: `alu_op`=00, `alu_src`=1. ADDI goes to WB; LW and SW go to MEM.
  - BEQ: `alu_op`=01, `pc_src`=01, `pc_write`=`zero`. Retires, goes to FETCH.
  - J: `pc_src`=10, `pc_write`=1. Retires, goes to FETCH.
- MEM: `alu_src`=1 and `alu_op`=00 are held.
  - LW: `mem_read`=1; SW: `mem_write`=1.
  - Stay in MEM while `mem_ready`=0.
  - On `mem_ready`=1: LW goes to WB; SW retires and goes to FETCH.
- WB: `reg_write`=1.
  - RTYPE: `reg_dst`=1, `mem_to_reg`=0.
  - ADDI: `reg_dst`=0, `mem_to_reg`=0.
  - LW: `reg_dst`=0, `mem_to_reg`=1.
  - Retires, goes to FETCH.
- HALT: all controls 0, `halted`=1. Left only through reset.
- Retire: `instr_count` increments by 1 on the final-cycle edge of each instruction, and wraps modulo 2^CNT_W. HALT is not counted.
- `illegal_op`: set on the DECODE edge of an illegal opcode. Cleared only by reset.

## Timing
- Control outputs are Moore-combinational from the state and latched opcode. `ir_write` and the FETCH/MEM transitions also depend on `mem_ready`, and `pc_write` in BEQ depends on `zero`.
- Reset, while `rst_n` is low: state START, every output 0, `instr_count`=0, `illegal_op`=0.
- Reset asserted mid-instruction: outputs go to 0 immediately (asynchronous); an in-flight memory access is abandoned.
- Cycle counts with `mem_ready` tied high: RTYPE 4, ADDI 4, LW 5, SW 4, BEQ 3, J 3, NOP 2, illegal 2.
- Each `mem_ready`=0 cycle in FETCH or MEM adds exactly one cycle.
- `mem_ready` in any other state is ignored.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants, parametrised by OPCODE_W;
  - the state enum;
  - `alu_op` codes;
  - `pc_src` codes.
- One sub-module, `mc_ctrl_decode`: combinational map from (state, opcode, zero, mem_ready) to the control outputs.
- The state register, opcode latch, counter and flag live in `mc_control_unit`.

## Test plan
- RTYPE with `mem_ready`=1 → states FETCH, DECODE, EXEC, WB.
  - WB has `reg_write`=1, `reg_dst`=1, `alu_op` was 10 in EXEC.
  - `instr_count` goes 0→1 after 4 cycles.
- LW with `mem_ready` low for 2 cycles in both FETCH and MEM → 9 cycles total.
  - `ir_write` is high only on the FETCH ready cycle.
  - WB has `mem_to_reg`=1.
- BEQ with `zero`=1 → EXEC `pc_write`=1, `pc_src`=01.
  - Repeat with `zero`=0 → `pc_write`=0.
  - Both take 3 cycles.
- Opcode 4'b1001 → `illegal_op`=1 after DECODE, `instr_count`+1, back to FETCH.
  - The flag stays high through the following legal instructions.
- HALT → `halted`=1 with all controls 0 for 20 cycles.
  - Pulse `rst_n` low for 1 cycle → START, then FETCH with `mem_read`=1.
- Reset asserted during MEM of SW → `mem_write` drops to 0 in the same cycle and `instr_count`=0.
  - Also drive 2^16 NOPs → `instr_count` wraps to 0.
